// File: rtl/ascon_perm_ctrl.sv
// Round scheduler for the ASCON permutation: one state load followed by N rounds,
// driving the state-register enable, load/feedback select and round index.
module ascon_perm_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6,
  parameter int RW       = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          mode_i,
  output logic [RW-1:0] round_o,
  output logic          en_reg_state_o,
  output logic          sel_state_o,
  output logic          last_round_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } state_t;

  // Every run ends on index 11, so a shorter permutation simply starts later.
  localparam logic [RW-1:0] LAST_ROUND   = RW'(11);
  localparam logic [RW-1:0] PRE_LAST     = RW'(10);
  localparam logic [RW-1:0] FIRST_ROUND_A = RW'(12 - ROUNDS_A);
  localparam logic [RW-1:0] FIRST_ROUND_B = RW'(12 - ROUNDS_B);

  state_t state;

  // Outputs are registered alongside the state, so each branch assigns the
  // values that belong to the state being entered.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      round_o        <= '0;
      en_reg_state_o <= 1'b0;
      sel_state_o    <= 1'b0;
      last_round_o   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // the same block; every output therefore has a defined value each cycle.
      en_reg_state_o <= 1'b0;
      sel_state_o    <= 1'b0;
      last_round_o   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_i) begin
            state          <= LOAD;
            round_o        <= mode_i ? FIRST_ROUND_B : FIRST_ROUND_A;
            en_reg_state_o <= 1'b1;
            busy_o         <= 1'b1;
          end
        end

        LOAD: begin
          state          <= ROUND;
          en_reg_state_o <= 1'b1;
          sel_state_o    <= 1'b1;
          busy_o         <= 1'b1;
          last_round_o   <= (round_o == LAST_ROUND);
        end

        ROUND: begin
          if (round_o == LAST_ROUND) begin
            state       <= DONE;
            sel_state_o <= 1'b1;
            done_o      <= 1'b1;
          end else begin
            round_o        <= round_o + RW'(1);
            en_reg_state_o <= 1'b1;
            sel_state_o    <= 1'b1;
            busy_o         <= 1'b1;
            last_round_o   <= (round_o == PRE_LAST);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: a schedule-queue reference model predicts
// every output each cycle; scenario tasks add latency and spacing checks.
module tb_ascon_perm_ctrl;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;
  localparam int RW       = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [RW-1:0] round_o;
  logic          en_reg_state_o, sel_state_o, last_round_o, busy_o, done_o;

  ascon_perm_ctrl #(
    .ROUNDS_A(ROUNDS_A),
    .ROUNDS_B(ROUNDS_B),
    .RW      (RW)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .start_i       (start),
    .mode_i        (mode),
    .round_o       (round_o),
    .en_reg_state_o(en_reg_state_o),
    .sel_state_o   (sel_state_o),
    .last_round_o  (last_round_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Output bundle: {round, en, sel, last, busy, done}
  logic [8:0] obs;
  assign obs = {round_o, en_reg_state_o, sel_state_o, last_round_o, busy_o, done_o};

  function automatic logic [8:0] mk(int r, bit en, bit sel, bit last, bit busy, bit done);
    logic [3:0] r4;
    r4 = 4'(r);
    return {r4, en, sel, last, busy, done};
  endfunction

  // Reference model: a run is a precomputed list of per-cycle outputs; idle cycles
  // repeat the last round index with everything else low.
  logic [8:0] sched[$];
  logic [8:0] exp_cur;
  int         held_round = 0;

  function automatic void model_edge(bit s, bit m, bit r);
    int n;
    if (r) begin
      sched.delete();
      held_round = 0;
      exp_cur    = mk(0, 0, 0, 0, 0, 0);
      return;
    end
    if (sched.size() == 0 && exp_cur[0] == 1'b0 && s) begin
      n = m ? ROUNDS_B : ROUNDS_A;
      sched.push_back(mk(12 - n, 1, 0, 0, 1, 0));
      for (int k = 0; k < n; k++)
        sched.push_back(mk(12 - n + k, 1, 1, (k == n - 1), 1, 0));
      sched.push_back(mk(11, 0, 1, 0, 0, 1));
    end
    if (sched.size() != 0) begin
      exp_cur    = sched.pop_front();
      held_round = int'(exp_cur[8:5]);
    end else begin
      exp_cur = mk(held_round, 0, 0, 0, 0, 0);
    end
  endfunction

  // Drive inputs mid-cycle, advance one edge, then settle past it before sampling.
  task automatic cycle(input bit s, input bit m, input bit r);
    @(negedge clk);
    start = s;
    mode  = m;
    rst   = r;
    @(posedge clk);
    model_edge(s, m, r);
    #1;
  endtask

  task automatic test_reset;
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0))
      $display("FAIL reset_outputs: got %h want %h", obs, mk(0, 0, 0, 0, 0, 0));
    else passed++;
    cycle(0, 0, 0);
    total++;
    if (obs !== exp_cur) $display("FAIL reset_idle: got %h want %h", obs, exp_cur);
    else passed++;
  endtask

  task automatic test_single(input bit m);
    int n, lat, busy_cnt, done_lat, sel0_cnt;
    n        = m ? ROUNDS_B : ROUNDS_A;
    busy_cnt = 0;
    done_lat = -1;
    sel0_cnt = 0;
    cycle(1, m, 0);
    lat = 1;
    for (int i = 0; i < n + 4; i++) begin
      total++;
      if (obs !== exp_cur) $display("FAIL single_m%0d_cyc%0d: got %h want %h", m, lat, obs, exp_cur);
      else passed++;
      if (busy_o) busy_cnt++;
      if (busy_o && !sel_state_o) sel0_cnt++;
      if (done_o && done_lat < 0) done_lat = lat;
      cycle(0, ~m, 0);
      lat++;
    end
    total++;
    if (done_lat != n + 2) $display("FAIL latency_m%0d: got %0d want %0d", m, done_lat, n + 2);
    else passed++;
    total++;
    if (busy_cnt != n + 1) $display("FAIL busy_len_m%0d: got %0d want %0d", m, busy_cnt, n + 1);
    else passed++;
    total++;
    if (sel0_cnt != 1) $display("FAIL load_sel_m%0d: got %0d want 1", m, sel0_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int last_load, gaps_bad, loads, done_w;
    last_load = -1;
    gaps_bad  = 0;
    loads     = 0;
    done_w    = 0;
    for (int i = 0; i < 4 * (ROUNDS_A + 3); i++) begin
      cycle(1, 0, 0);
      total++;
      if (obs !== exp_cur) $display("FAIL b2b_cyc%0d: got %h want %h", i, obs, exp_cur);
      else passed++;
      if (en_reg_state_o && !sel_state_o) begin
        if (last_load >= 0 && i - last_load != ROUNDS_A + 3) gaps_bad++;
        last_load = i;
        loads++;
      end
      if (done_o) done_w++;
      else done_w = 0;
      if (done_w > 1) gaps_bad++;
    end
    total++;
    if (gaps_bad != 0 || loads != 4)
      $display("FAIL b2b_spacing: bad=%0d loads=%0d want bad=0 loads=4", gaps_bad, loads);
    else passed++;
    for (int i = 0; i < ROUNDS_A + 3; i++) cycle(0, 0, 0);
  endtask

  task automatic test_reset_mid;
    int guard, dones;
    guard = 0;
    dones = 0;
    cycle(1, 0, 0);
    while (!(busy_o && sel_state_o && round_o == 4'd5) && guard < 30) begin
      cycle(0, 0, 0);
      guard++;
    end
    total++;
    if (guard >= 30) $display("FAIL reset_mid_reach: round 5 not seen, got %0d want 5", round_o);
    else passed++;
    cycle(1, 0, 1);
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0)) $display("FAIL reset_mid_clear: got %h want 0", obs);
    else passed++;
    for (int i = 0; i < ROUNDS_A + 4; i++) begin
      cycle(0, 0, 0);
      if (done_o) dones++;
      total++;
      if (obs !== exp_cur) $display("FAIL reset_mid_after%0d: got %h want %h", i, obs, exp_cur);
      else passed++;
    end
    total++;
    if (dones != 0) $display("FAIL reset_mid_nodone: got %0d want 0", dones);
    else passed++;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    total++;
    if (obs !== mk(0, 1, 1, 0, 1, 0)) $display("FAIL reset_mid_restart: got %h want %h", obs, mk(0, 1, 1, 0, 1, 0));
    else passed++;
    for (int i = 0; i < ROUNDS_A + 3; i++) cycle(0, 0, 0);
  endtask

  task automatic test_random;
    bit s, m, r;
    for (int i = 0; i < 600; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 79) == 0);
      cycle(s, m, r);
      total++;
      if (obs !== exp_cur) $display("FAIL random_cyc%0d: got %h want %h", i, obs, exp_cur);
      else passed++;
      total++;
      if (round_o > 4'd11) $display("FAIL random_range%0d: got %0d want <=11", i, round_o);
      else passed++;
    end
  endtask

  initial begin
    exp_cur = mk(0, 0, 0, 0, 0, 0);
    test_reset;
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
